alu: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_if.sv | 16 +
 rtl/alu_muldiv.sv | 35 +++
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and the flags register layout.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_MOD  = 4'd4,
    ALU_CMP  = 4'd5,
    ALU_AND  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_NOT  = 4'd8,
    ALU_MOV  = 4'd9,
    ALU_LSL  = 4'd10,
    ALU_LSR  = 4'd11,
    ALU_ASR  = 4'd12,
    ALU_XOR  = 4'd13,
    ALU_NOR  = 4'd14,
    ALU_RSVD = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic eq;
    logic gt;
  } alu_flags_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage control and the ALU.
interface alu_if;
  import alu_pkg::*;

  logic [31:0] a;
  logic [31:0] b;
  alu_op_e     op;
  logic        flag_we;
  logic [31:0] y;
  logic        zero;
  logic        flag_eq;
  logic        flag_gt;

  modport master (output a, b, op, flag_we, input y, zero, flag_eq, flag_gt);
  modport slave  (input a, b, op, flag_we, output y, zero, flag_eq, flag_gt);
endinterface

// File: rtl/alu_muldiv.sv
// Combinational MUL/DIV/MOD, signed truncating division with defined corner cases.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] y_o
);

  logic div0, ovf;

  assign div0 = (b_i == 32'h0);
  // INT_MIN / -1 overflows; pin the result instead of leaving it tool-defined
  assign ovf  = (a_i == INT_MIN) && (b_i == 32'hFFFF_FFFF);

  always_comb begin
    y_o = 32'h0;
    case (op_i)
      ALU_MUL: y_o = a_i * b_i;
      ALU_DIV: begin
        if (div0)     y_o = 32'hFFFF_FFFF;
        else if (ovf) y_o = INT_MIN;
        else          y_o = $signed(a_i) / $signed(b_i);
      end
      ALU_MOD: begin
        if (div0)     y_o = a_i;
        else if (ovf) y_o = 32'h0;
        else          y_o = $signed(a_i) % $signed(b_i);
      end
      default: y_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 32-bit execute-stage ALU with a CMP-loaded EQ/GT flags register.
// ALU_MULDIV_EN enables MUL/DIV/MOD; otherwise those codes behave as reserved.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [31:0] y_d;
  logic [31:0] diff;
  logic [31:0] md_y;
  alu_flags_t  flags_q, flags_d;

  assign diff = bus.a - bus.b;

`ifdef ALU_MULDIV_EN
  alu_muldiv u_muldiv (
    .a_i  (bus.a),
    .b_i  (bus.b),
    .op_i (bus.op),
    .y_o  (md_y)
  );
`else
  assign md_y = 32'h0;
`endif

  always_comb begin
    y_d = 32'h0;
    case (bus.op)
      ALU_ADD: y_d = bus.a + bus.b;
      ALU_SUB,
      ALU_CMP: y_d = diff;
      ALU_MUL,
      ALU_DIV,
      ALU_MOD: y_d = md_y;
      ALU_AND: y_d = bus.a & bus.b;
      ALU_OR:  y_d = bus.a | bus.b;
      ALU_NOT: y_d = ~bus.b;
      ALU_MOV: y_d = bus.b;
      ALU_LSL: y_d = bus.a << bus.b[4:0];
      ALU_LSR: y_d = bus.a >> bus.b[4:0];
      ALU_ASR: y_d = $signed(bus.a) >>> bus.b[4:0];
      ALU_XOR: y_d = bus.a ^ bus.b;
      ALU_NOR: y_d = ~(bus.a | bus.b);
      default: y_d = 32'h0;
    endcase
  end

  assign bus.y    = y_d;
  assign bus.zero = (y_d == 32'h0);

  always_comb begin
    flags_d = flags_q;
    if (bus.flag_we && bus.op == ALU_CMP) begin
      flags_d.eq = (bus.a == bus.b);
      flags_d.gt = ($signed(bus.a) > $signed(bus.b));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign bus.flag_eq = flags_q.eq;
  assign bus.flag_gt = flags_q.gt;

endmodule

// File: tb/tb_alu.sv
// Directed and randomised checks of the ALU result, zero and flags.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_if bus ();

  alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Independent reference for y
  function automatic logic [31:0] ref_y(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      0:  return a + b;
      1, 5: return a + (~b) + 32'd1;
`ifdef ALU_MULDIV_EN
      2:  return 32'(longint'(a) * longint'(b));
      3:  return (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sb);
      4:  return (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
`endif
      6:  return a & b;
      7:  return a | b;
      8:  return ~b;
      9:  return b;
      10: return 32'(longint'(a) << (b % 32));
      11: return 32'(longint'(a) >> (b % 32));
      12: return 32'(sa >>> (b % 32));
      13: return a ^ b;
      14: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    bus.a = 32'h0; bus.b = 32'h0; bus.op = ALU_ADD; bus.flag_we = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.flag_eq, bus.flag_gt} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags got=%b exp=00", {bus.flag_eq, bus.flag_gt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [31:0] ta [3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF};
    logic [31:0] tb [3] = '{32'h7FFFFFFF, 32'h00000001, 32'hCAFEBABE};
    logic [31:0] ty [3] = '{32'hFFFFFFFE, 32'h00000000, 32'hA9AC79AD};
    logic        tz [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus.op = ALU_ADD; bus.a = ta[i]; bus.b = tb[i];
      #1;
      n_cmp++;
      if (bus.y !== ty[i] || bus.zero !== tz[i]) begin
        n_err++; $display("FAIL add%0d y=%h z=%b exp y=%h z=%b", i, bus.y, bus.zero, ty[i], tz[i]);
      end
    end
  endtask

  task automatic test_sub_shift();
    alu_op_e     to [7] = '{ALU_SUB, ALU_ASR, ALU_LSR, ALU_ASR, ALU_LSR, ALU_LSL, ALU_NOT};
    logic [31:0] ta [7] = '{32'h5, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000003, 32'h0};
    logic [31:0] tb [7] = '{32'h5, 32'h00000024, 32'h00000024, 32'h00000023, 32'h00000023, 32'hFFFFFFFF, 32'h0F0F0F0F};
    logic [31:0] ty [7] = '{32'h0, 32'hF8000000, 32'h08000000, 32'hF0000000, 32'h10000000, 32'h80000000, 32'hF0F0F0F0};
    for (int i = 0; i < 7; i++) begin
      bus.op = to[i]; bus.a = ta[i]; bus.b = tb[i];
      #1;
      n_cmp++;
      if (bus.y !== ty[i] || bus.zero !== (ty[i] == 32'h0)) begin
        n_err++; $display("FAIL subshift%0d y=%h z=%b exp y=%h", i, bus.y, bus.zero, ty[i]);
      end
    end
  endtask

  task automatic test_cmp_flags();
    alu_op_e     to [6] = '{ALU_CMP, ALU_CMP, ALU_CMP, ALU_CMP, ALU_ADD, ALU_CMP};
    logic [31:0] ta [6] = '{32'h5, 32'hFFFFFFFF, 32'h3, 32'h5, 32'h5, 32'h80000000};
    logic [31:0] tb [6] = '{32'h3, 32'h1, 32'h3, 32'h3, 32'h3, 32'h7FFFFFFF};
    logic        tw [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  tf [6] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.op = to[i]; bus.a = ta[i]; bus.b = tb[i]; bus.flag_we = tw[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.flag_eq, bus.flag_gt} !== tf[i]) begin
        n_err++; $display("FAIL cmp%0d flags(eq,gt)=%b exp=%b", i, {bus.flag_eq, bus.flag_gt}, tf[i]);
      end
    end
    @(negedge clk);
    bus.flag_we = 1'b0;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    bus.op = ALU_CMP; bus.a = 32'h3; bus.b = 32'h3; bus.flag_we = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.flag_eq, bus.flag_gt} !== 2'b10) begin
      n_err++; $display("FAIL rstprio_set flags=%b exp=10", {bus.flag_eq, bus.flag_gt});
    end
    @(negedge clk);
    bus.a = 32'h9; bus.b = 32'h2; rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.flag_eq, bus.flag_gt} !== 2'b00) begin
      n_err++; $display("FAIL rstprio_clr flags=%b exp=00", {bus.flag_eq, bus.flag_gt});
    end
    n_cmp++;
    if (bus.y !== 32'h7 || bus.zero !== 1'b0) begin
      n_err++; $display("FAIL rst_y y=%h z=%b exp y=00000007 z=0", bus.y, bus.zero);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.flag_we = 1'b0;
  endtask

  task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
    alu_op_e     to [6] = '{ALU_DIV, ALU_MOD, ALU_DIV, ALU_MUL, ALU_DIV, ALU_MOD};
    logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678, 32'h10000, 32'h80000000, 32'h80000000};
    logic [31:0] tb [6] = '{32'h2, 32'h2, 32'h0, 32'h10000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ty [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h0};
`else
    alu_op_e     to [6] = '{ALU_MUL, ALU_DIV, ALU_MOD, ALU_MUL, ALU_DIV, ALU_MOD};
    logic [31:0] ta [6] = '{32'h2, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h10000, 32'h12345678, 32'h12345678};
    logic [31:0] tb [6] = '{32'h3, 32'h2, 32'h2, 32'h10001, 32'h0, 32'h0};
    logic [31:0] ty [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
    for (int i = 0; i < 6; i++) begin
      bus.op = to[i]; bus.a = ta[i]; bus.b = tb[i];
      #1;
      n_cmp++;
      if (bus.y !== ty[i] || bus.zero !== (ty[i] == 32'h0)) begin
        n_err++; $display("FAIL muldiv%0d y=%h z=%b exp y=%h", i, bus.y, bus.zero, ty[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, ey;
    int          errs_here;
    errs_here = 0;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 2000; k++) begin
        ra = $urandom; rb = $urandom;
        if (k % 50 == 7)  rb = 32'h0;
        if (k % 97 == 11) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        if (k % 13 == 3)  rb = rb % 32'd33;
        bus.op = alu_op_e'(op); bus.a = ra; bus.b = rb;
        #1;
        ey = ref_y(op, ra, rb);
        n_cmp++;
        if (bus.y !== ey || bus.zero !== (ey == 32'h0)) begin
          n_err++;
          if (errs_here < 10)
            $display("FAIL rand op=%0d a=%h b=%h y=%h z=%b exp y=%h", op, ra, rb, bus.y, bus.zero, ey);
          errs_here++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_cmp_flags();
    test_reset_priority();
    test_muldiv();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
